result_router_acc: RTL

- Parametrised successor of the psum result router.
- Aligns skewed psum streams from NUM_KCPE kernel-channel PEs through per-KCPE FIFOs, then adds them per kernel in signed arithmetic.
- Accumulates the per-kernel sums over a configurable number of channel-group passes, with optional saturation.
- Delivers one accumulated vector per output transaction on a valid/ready handshake to the accumulator memory.

---
 rtl/result_router_acc.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/result_router_acc.sv
// Aligns skewed psum streams from NUM_KCPE sources, adds them per kernel and
// accumulates over a configurable number of passes before handing the vector downstream.
//
// state | meaning
// IDLE  | pass_cnt == 0, next pop starts a new group and samples i_num_pass
// ACC   | pass_cnt != 0, pops add onto the running accumulator
module result_router_acc #(
    parameter int BIT_WIDTH  = 8,
    parameter int NUM_KCPE   = 3,
    parameter int NUM_KERNEL = 4,
    parameter int ACC_WIDTH  = 24,
    parameter int FIFO_DEPTH = 4,
    parameter int PASS_W     = 4,
    parameter int SATURATE   = 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_KCPE*NUM_KERNEL*2*BIT_WIDTH-1:0] i_psum,
    input  logic [NUM_KCPE-1:0]                    i_psum_vld,
    output logic [NUM_KCPE-1:0]                    o_psum_rdy,
    input  logic [PASS_W-1:0]                      i_num_pass,
    input  logic                                   i_flush,
    output logic [NUM_KERNEL*ACC_WIDTH-1:0]        o_psum,
    output logic                                   o_psum_vld,
    input  logic                                   i_psum_rdy,
    output logic                                   o_busy,
    output logic                                   o_ovf
);

    localparam int PW     = 2*BIT_WIDTH;
    localparam int BEAT_W = NUM_KERNEL*PW;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int SW     = ACC_WIDTH + 1;

    localparam logic [AW:0]           PTR_ONE  = 1;
    localparam logic [PASS_W-1:0]     PASS_ONE = 1;
    localparam logic [ACC_WIDTH-1:0]  SAT_MAX  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0]  SAT_MIN  = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic {IDLE, ACC} state_t;
    state_t state;

    logic [PASS_W-1:0]               pass_cnt, pass_cnt_d, np_q, np_d, np_in, np_cur;
    logic [NUM_KERNEL*ACC_WIDTH-1:0] acc_q, acc_d, res, out_d;
    logic [NUM_KERNEL-1:0]           lane_ovf;
    logic [BEAT_W-1:0]               head [NUM_KCPE];
    logic [NUM_KCPE-1:0]             empty, full, push;
    logic                            last, pop, vld_d, ovf_d;

    for (genvar k = 0; k < NUM_KCPE; k++) begin : g_fifo
        logic [BEAT_W-1:0] mem [FIFO_DEPTH];
        logic [AW:0]       wr_ptr, rd_ptr;

        assign empty[k] = (wr_ptr == rd_ptr);
        assign full[k]  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        assign push[k]  = i_psum_vld[k] & ~full[k] & ~i_flush;
        assign head[k]  = mem[rd_ptr[AW-1:0]];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else if (i_flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push[k]) wr_ptr <= wr_ptr + PTR_ONE;
                if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
            end
        end

        always_ff @(posedge clk) begin
            if (push[k]) mem[wr_ptr[AW-1:0]] <= i_psum[k*BEAT_W +: BEAT_W];
        end
    end

    assign o_psum_rdy = ~full;
    assign o_busy     = (pass_cnt != '0);
    assign state      = (pass_cnt == '0) ? IDLE : ACC;

    assign np_in  = (i_num_pass == '0) ? PASS_ONE : i_num_pass;
    assign np_cur = (state == IDLE) ? np_in : np_q;
    assign last   = (pass_cnt == np_cur - PASS_ONE);
    // Only the last pass needs the output register free; earlier passes may run ahead.
    assign pop    = (&(~empty)) & (~last | ~o_psum_vld | i_psum_rdy) & ~i_flush;

    for (genvar n = 0; n < NUM_KERNEL; n++) begin : g_lane
        logic [SW-1:0]        lane_sum, acc_ext, total;
        logic [ACC_WIDTH-1:0] lane_res;
        logic                 ovf_n;

        always_comb begin
            lane_sum = '0;
            for (int k = 0; k < NUM_KCPE; k++) begin
                lane_sum = lane_sum + {{(SW-PW){head[k][n*PW+PW-1]}}, head[k][n*PW +: PW]};
            end
            acc_ext = (state == ACC) ? {acc_q[n*ACC_WIDTH+ACC_WIDTH-1], acc_q[n*ACC_WIDTH +: ACC_WIDTH]} : '0;
            total   = acc_ext + lane_sum;
            ovf_n   = total[SW-1] ^ total[SW-2];
            if (ovf_n && (SATURATE != 0)) lane_res = total[SW-1] ? SAT_MIN : SAT_MAX;
            else                          lane_res = total[ACC_WIDTH-1:0];
        end

        assign res[n*ACC_WIDTH +: ACC_WIDTH] = lane_res;
        assign lane_ovf[n] = ovf_n;
    end

    always_comb begin
        pass_cnt_d = pass_cnt;
        np_d       = np_q;
        acc_d      = acc_q;
        out_d      = o_psum;
        vld_d      = o_psum_vld & ~i_psum_rdy;
        ovf_d      = o_ovf;
        if (i_flush) begin
            pass_cnt_d = '0;
            acc_d      = '0;
            vld_d      = 1'b0;
            ovf_d      = 1'b0;
        end else if (pop) begin
            if (state == IDLE) np_d = np_in;
            acc_d = res;
            ovf_d = o_ovf | (|lane_ovf);
            if (last) begin
                pass_cnt_d = '0;
                out_d      = res;
                vld_d      = 1'b1;
            end else begin
                pass_cnt_d = pass_cnt + PASS_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pass_cnt   <= '0;
            np_q       <= PASS_ONE;
            acc_q      <= '0;
            o_psum     <= '0;
            o_psum_vld <= 1'b0;
            o_ovf      <= 1'b0;
        end else begin
            pass_cnt   <= pass_cnt_d;
            np_q       <= np_d;
            acc_q      <= acc_d;
            o_psum     <= out_d;
            o_psum_vld <= vld_d;
            o_ovf      <= ovf_d;
        end
    end

endmodule
